// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and requester IDs for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-over-fetch winner selection with a starvation guard on consecutive data grants
// Ports: Clock/Reset; If_req_i, D_req_i requests; en_i grant enable (arbiter idle);
//        win_o winner ID (REQ_IF/REQ_D); gnt_o a grant is made this cycle
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic If_req_i,
    input  logic D_req_i,
    input  logic en_i,
    output logic win_o,
    output logic gnt_o
);
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       fetch_win;
    logic       run_full;
    always_comb begin
        run_full  = run_cnt_q == 4'(MAX_DATA_RUN);
        // fetch wins when alone, or when the data run has used up its budget
        fetch_win = If_req_i && (!D_req_i || run_full);
        win_o     = fetch_win ? REQ_IF : REQ_D;
        gnt_o     = en_i && !Reset && (If_req_i || D_req_i);
        run_cnt_d = run_cnt_q;
        if (gnt_o)
            run_cnt_d = (fetch_win || !If_req_i) ? 4'd0 : (run_full ? run_cnt_q : run_cnt_q + 4'd1);
    end
    always_ff @(posedge Clock) begin
        run_cnt_q <= Reset ? 4'd0 : run_cnt_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-transaction arbiter sharing one memory port between fetch and data paths
// Ports: Clock/Reset; If_req/If_addr -> If_gnt/If_valid/If_rdata fetch side;
//        D_req/D_we/D_addr/D_wdata -> D_gnt/D_valid/D_rdata data side;
//        Mem_en/Mem_we/Mem_addr/Mem_wdata/Mem_rdata memory side; Busy while a transaction is in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N            = 16,
    parameter int READ_LAT     = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         If_req,
    input  logic [N-1:0] If_addr,
    output logic         If_gnt,
    output logic         If_valid,
    output logic [N-1:0] If_rdata,
    input  logic         D_req,
    input  logic         D_we,
    input  logic [N-1:0] D_addr,
    input  logic [N-1:0] D_wdata,
    output logic         D_gnt,
    output logic         D_valid,
    output logic [N-1:0] D_rdata,
    output logic         Mem_en,
    output logic         Mem_we,
    output logic [N-1:0] Mem_addr,
    output logic [N-1:0] Mem_wdata,
    input  logic [N-1:0] Mem_rdata,
    output logic         Busy
);
    state_e       state_q, state_d;
    logic [2:0]   lat_q, lat_d;
    logic         win_q, we_q;
    logic [N-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic         win, gnt;

    mem_arb_pick #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_pick (
        .Clock    (Clock),
        .Reset    (Reset),
        .If_req_i (If_req),
        .D_req_i  (D_req),
        .en_i     (state_q == IDLE),
        .win_o    (win),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE:  state_d = gnt ? ISSUE : IDLE;
            ISSUE: begin
                state_d = we_q ? RESP : WAIT;
                lat_d   = 3'(READ_LAT - 1);
            end
            WAIT:  begin
                state_d = (lat_q == 3'd0) ? RESP : WAIT;
                lat_d   = lat_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            win_q      <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (gnt) begin
                win_q  <= win;
                we_q   <= (win == REQ_D) && D_we;
                addr_q <= (win == REQ_D) ? D_addr : If_addr;
                if (win == REQ_D) wdata_q <= D_wdata;
            end
            // only loads and fetches pass through WAIT, so stores never touch D_rdata
            if (state_q == WAIT && lat_q == 3'd0) begin
                if (win_q == REQ_D) d_rdata_q <= Mem_rdata;
                else if_rdata_q <= Mem_rdata;
            end
        end
    end

    assign If_gnt    = gnt && (win == REQ_IF);
    assign D_gnt     = gnt && (win == REQ_D);
    assign If_valid  = (state_q == RESP) && (win_q == REQ_IF);
    assign D_valid   = (state_q == RESP) && (win_q == REQ_D);
    assign If_rdata  = if_rdata_q;
    assign D_rdata   = d_rdata_q;
    assign Mem_en    = state_q == ISSUE;
    assign Mem_we    = we_q;
    assign Mem_addr  = addr_q;
    assign Mem_wdata = wdata_q;
    assign Busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed check of mem_port_arbiter against a transaction-timeline model
module tb_mem_port_arbiter;
    localparam int N  = 16;
    localparam int RL = 2;
    localparam int MR = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1, If_req = 1'b0, D_req = 1'b0, D_we = 1'b0;
    logic [N-1:0] If_addr = '0, D_addr = '0, D_wdata = '0, Mem_rdata = '0;
    logic         If_gnt, If_valid, D_gnt, D_valid, Mem_en, Mem_we, Busy;
    logic [N-1:0] If_rdata, D_rdata, Mem_addr, Mem_wdata;

    int n_chk = 0, n_err = 0, cyc = 0;

    // stimulus state: a pending request is held until the model says it was granted
    bit           rst = 1'b1, pend_if = 1'b0, pend_d = 1'b0, dwe = 1'b0;
    logic [N-1:0] ifa = '0, da = '0, dwd = '0;

    // memory seen by the DUT, and the model's own copy updated from requests
    logic [N-1:0] env_mem [256];
    logic [N-1:0] ref_mem [256];
    int           rd_due = -1;
    logic [N-1:0] rd_dat = '0;

    // transaction timeline model
    int           free_at = 0, gcyc = -100, run = 0;
    bit           cur_d = 1'b0, cur_we = 1'b0, e_mwe = 1'b0, e_mwd_ok = 1'b1;
    logic [N-1:0] cur_data = '0, e_maddr = '0, e_mwd = '0, e_ifrd = '0, e_drd = '0;

    mem_port_arbiter #(.N(N), .READ_LAT(RL), .MAX_DATA_RUN(MR)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .If_req    (If_req),
        .If_addr   (If_addr),
        .If_gnt    (If_gnt),
        .If_valid  (If_valid),
        .If_rdata  (If_rdata),
        .D_req     (D_req),
        .D_we      (D_we),
        .D_addr    (D_addr),
        .D_wdata   (D_wdata),
        .D_gnt     (D_gnt),
        .D_valid   (D_valid),
        .D_rdata   (D_rdata),
        .Mem_en    (Mem_en),
        .Mem_we    (Mem_we),
        .Mem_addr  (Mem_addr),
        .Mem_wdata (Mem_wdata),
        .Mem_rdata (Mem_rdata),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit           idle, wd, gi, gd, rdv;
        logic [N-1:0] a;
        @(posedge Clock);
        cyc++;
        #1;
        Reset     = rst;
        If_req    = pend_if;
        If_addr   = ifa;
        D_req     = pend_d;
        D_we      = dwe;
        D_addr    = da;
        D_wdata   = dwd;
        Mem_rdata = (cyc == rd_due) ? rd_dat : N'($urandom);
        @(negedge Clock);
        idle = cyc >= free_at;
        wd   = pend_d && !(pend_if && run == MR);
        gi   = idle && !rst && pend_if && !wd;
        gd   = idle && !rst && wd;
        chk("if_gnt", 32'(If_gnt), 32'(gi));
        chk("d_gnt", 32'(D_gnt), 32'(gd));
        chk("busy", 32'(Busy), 32'(!idle));
        chk("mem_en", 32'(Mem_en), 32'(cyc == gcyc + 1));
        chk("mem_addr", 32'(Mem_addr), 32'(e_maddr));
        chk("mem_we", 32'(Mem_we), 32'(e_mwe));
        if (e_mwd_ok) chk("mem_wdata", 32'(Mem_wdata), 32'(e_mwd));
        rdv = (cyc == free_at - 1) && (gcyc >= 0);
        if (rdv && !cur_d) e_ifrd = cur_data;
        if (rdv && cur_d && !cur_we) e_drd = cur_data;
        chk("if_valid", 32'(If_valid), 32'(rdv && !cur_d));
        chk("d_valid", 32'(D_valid), 32'(rdv && cur_d));
        chk("if_rdata", 32'(If_rdata), 32'(e_ifrd));
        chk("d_rdata", 32'(D_rdata), 32'(e_drd));
        chk("run_cnt", 32'(dut.u_pick.run_cnt_q), 32'(run));
        if (Mem_en) begin
            if (Mem_we) env_mem[Mem_addr[7:0]] = Mem_wdata;
            else begin
                rd_due = cyc + RL;
                rd_dat = env_mem[Mem_addr[7:0]];
            end
        end
        if (rst) begin
            free_at  = 0;
            gcyc     = -100;
            run      = 0;
            e_maddr  = '0;
            e_mwe    = 1'b0;
            e_mwd    = '0;
            e_mwd_ok = 1'b1;
            e_ifrd   = '0;
            e_drd    = '0;
        end else if (gi || gd) begin
            a        = gd ? da : ifa;
            gcyc     = cyc;
            cur_d    = gd;
            cur_we   = gd && dwe;
            e_maddr  = a;
            e_mwe    = cur_we;
            e_mwd_ok = gd;
            if (gd) e_mwd = dwd;
            if (cur_we) ref_mem[a[7:0]] = dwd;
            cur_data = ref_mem[a[7:0]];
            free_at  = cyc + 3 + (cur_we ? 0 : RL);
            run      = gi ? 0 : (pend_if ? (run < MR ? run + 1 : MR) : 0);
            if (gi) pend_if = 1'b0;
            else pend_d = 1'b0;
        end
    endtask

    initial begin
        logic [9:0] seq;
        int         n_g;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = N'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[8'h10] = 16'hABCD;
        ref_mem[8'h10] = 16'hABCD;
        repeat (2) step();
        rst = 1'b0;
        step();
        // single fetch
        pend_if = 1'b1;
        ifa     = 16'h0010;
        repeat (8) step();
        chk("fetch_word", 32'(If_rdata), 32'h0000ABCD);
        // single store
        pend_d = 1'b1;
        dwe    = 1'b1;
        da     = 16'h0200;
        dwd    = 16'h1234;
        repeat (4) step();
        chk("store_commit", 32'(env_mem[8'h00]), 32'h00001234);
        // simultaneous load and fetch
        pend_d  = 1'b1;
        dwe     = 1'b0;
        da      = 16'h0300;
        pend_if = 1'b1;
        ifa     = 16'h0040;
        repeat (12) step();
        // starvation guard with both requests held continuously
        seq = '0;
        n_g = 0;
        for (int k = 0; k < 80; k++) begin
            if (!pend_if) begin
                pend_if = 1'b1;
                ifa     = N'($urandom);
            end
            if (!pend_d) begin
                pend_d = 1'b1;
                dwe    = 1'b0;
                da     = N'($urandom);
            end
            step();
            if ((If_gnt || D_gnt) && n_g < 10) begin
                seq = {seq[8:0], If_gnt};
                n_g++;
            end
        end
        chk("starve_grants", 32'(n_g), 32'd10);
        chk("starve_order", 32'(seq), 32'h021);
        pend_if = 1'b0;
        pend_d  = 1'b0;
        repeat (8) step();
        // reset during the second WAIT cycle of a fetch
        pend_if = 1'b1;
        ifa     = 16'h0010;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        pend_if = 1'b1;
        repeat (7) step();
        chk("refetch_word", 32'(If_rdata), 32'h0000ABCD);
        // fetch request appears during a load and is withdrawn before idle
        pend_d = 1'b1;
        dwe    = 1'b0;
        da     = 16'h0300;
        step();
        pend_if = 1'b1;
        ifa     = 16'h0055;
        repeat (2) step();
        pend_if = 1'b0;
        repeat (6) step();
        // randomized traffic with occasional withdrawals and resets
        repeat (3000) begin
            if (!pend_if && $urandom_range(3) == 0) begin
                pend_if = 1'b1;
                ifa     = N'($urandom);
            end else if (pend_if && $urandom_range(39) == 0) pend_if = 1'b0;
            if (!pend_d && $urandom_range(3) == 0) begin
                pend_d = 1'b1;
                dwe    = 1'($urandom_range(1));
                da     = N'($urandom);
                dwd    = N'($urandom);
            end else if (pend_d && $urandom_range(39) == 0) pend_d = 1'b0;
            rst = $urandom_range(299) == 0;
            step();
        end
        rst     = 1'b0;
        pend_if = 1'b0;
        pend_d  = 1'b0;
        repeat (8) step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's single-ported unified memory between the instruction-fetch path (driven from the program counter) and the data path (load/store address and write data from the ALU/shift mux and register file). Only one transaction is in flight at a time. Data accesses have priority over fetch, with a starvation guard that forces a fetch grant after a bounded run of data grants. Per-requester valid pulses tell the PC-write and register-write logic when each access has completed.

## Interface
- N, 16, data and address width
- READ_LAT, 2, memory read latency in cycles from `Mem_en` to valid `Mem_rdata`; legal range 1..7
- MAX_DATA_RUN, 4, maximum consecutive data grants while `If_req` is pending; legal range 1..15

- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- If_req  in  1  fetch request; held with `If_addr` stable until `If_gnt`
- If_addr  in  N  fetch address
- If_gnt  out  1  fetch granted this cycle (combinational, IDLE only)
- If_valid  out  1  one-cycle pulse: `If_rdata` holds the fetched word
- If_rdata  out  N  fetched word; holds until the next fetch completes
- D_req  in  1  data request; held with address, write enable and write data stable until `D_gnt`
- D_we  in  1  1 = store, 0 = load
- D_addr  in  N  data address
- D_wdata  in  N  store data
- D_gnt  out  1  data granted this cycle (combinational, IDLE only)
- D_valid  out  1  one-cycle pulse: load data ready, or store committed
- D_rdata  out  N  load data; holds until the next load completes
- Mem_en  out  1  memory access strobe, one cycle per transaction
- Mem_we  out  1  memory write enable; qualified by `Mem_en`
- Mem_addr  out  N  memory address; registered
- Mem_wdata  out  N  memory write data; registered
- Mem_rdata  in  N  memory read data; valid exactly READ_LAT cycles after the `Mem_en` cycle
- Busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grants only happen here.
  - If a request is present, assert the winner's `gnt` for one cycle.
  - Latch the winner ID, address, write enable and write data into registers.
  - Next state is ISSUE.
- Winner selection:
  - `D_req` wins over `If_req`.
  - Exception: when both are asserted and `run_cnt == MAX_DATA_RUN`, the fetch wins.
- `run_cnt` (4 bits) update rules:
  - +1 on a data grant made while `If_req` is high.
  - Cleared on a data grant made while `If_req` is low.
  - Cleared on any fetch grant.
  - Saturates at MAX_DATA_RUN.
- ISSUE: drive `Mem_en=1` with the latched `Mem_we`, `Mem_addr` and `Mem_wdata`.
  - Store: next state is RESP.
  - Load/fetch: next state is WAIT.
- WAIT: lasts READ_LAT cycles, counted by a 3-bit down-counter. In the last WAIT cycle, capture `Mem_rdata` into the winner's rdata register. Next state is RESP.
- RESP: pulse the winner's `valid`. Next state is IDLE.
- Fetch transactions always have `Mem_we=0`. `D_rdata` is not updated on a store.
- A requester may deassert `req` at any time before its grant. That withdraws the request and no transaction occurs. `req` held high after `gnt` is treated as a new request in the next IDLE cycle.
- `Mem_addr`, `Mem_we` and `Mem_wdata` hold their last values outside ISSUE. `Mem_we` is only meaningful with `Mem_en`.

## Timing
- Grant in cycle t (IDLE). `Mem_en` in cycle t+1.
- Load/fetch `valid` in cycle t+2+READ_LAT. Store `valid` in cycle t+2.
- The earliest next grant is the cycle after RESP. Read throughput is one per READ_LAT+3 cycles; store throughput is one per 3 cycles.
- `gnt` is a combinational function of the IDLE state, the `req` inputs and `run_cnt`. All other outputs are registered.
- Reset values: state IDLE, `run_cnt`=0.
  - `If_gnt`, `D_gnt`, `If_valid`, `D_valid`, `Mem_en`, `Mem_we` and `Busy` are 0.
  - `If_rdata`, `D_rdata`, `Mem_addr` and `Mem_wdata` are 0.
- Reset in any state abandons the transaction. No `valid` is emitted for it, and `Mem_en` is 0 from the cycle after reset is sampled. A `req` present while `Reset` is high is not granted.
- Requests arriving in ISSUE, WAIT or RESP wait until IDLE.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester ID constants (REQ_IF=0, REQ_D=1)
- One sub-module, `mem_arb_pick`: winner selection plus the `run_cnt` register. It takes `If_req`, `D_req`, a grant-enable (`state==IDLE`) and `Reset`, and outputs the winner ID and a grant-valid signal.
- The FSM, latency counter, latched request registers and rdata registers live in the top module.

## Test plan
- Single fetch, READ_LAT=2, memory returns 0xABCD at 0x0010. `If_req` is high at cycle 0 with `If_addr`=0x0010. Required response:
  - `If_gnt` in cycle 0.
  - `Mem_en=1`, `Mem_we=0`, `Mem_addr`=0x0010 in cycle 1.
  - `If_valid` in cycle 4 with `If_rdata`=0xABCD.
  - `Busy` high in cycles 1–4.
- Store: `D_req`, `D_we=1`, 0x0200 ← 0x1234 at cycle 0. Required response:
  - `Mem_en`/`Mem_we`=1 with 0x0200/0x1234 in cycle 1.
  - `D_valid` in cycle 2.
  - `D_rdata` unchanged.
- Simultaneous `D_req` (load 0x0300) and `If_req` at cycle 0. Required response:
  - `D_gnt` in cycle 0; `D_valid` in cycle 4.
  - `If_gnt` in cycle 5, `Mem_addr` = fetch address in cycle 6.
- Starvation, MAX_DATA_RUN=4, both requests held continuously. Required grant order: D,D,D,D,I,D,D,D,D,I; `run_cnt` returns to 0 after each I.
- `Reset` pulsed in the second WAIT cycle of a fetch. Required response:
  - No `If_valid`.
  - `Mem_en`=0, `Busy`=0, all outputs at reset values.
  - A later `If_req` is granted and completes with normal timing.
- `If_req` asserted during a data load, then dropped before IDLE. Required response: no `If_gnt`, no fetch `Mem_en`, and `run_cnt` is cleared by the data grant.
